// File: rtl/fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pkg : widths, constants and queue entry type for fetch (rev 1.0)
// ------------------------------------------------------------------
package fetch_pkg;

  localparam int              XLEN      = 32;
  localparam int              DEPTH     = 2;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit_if : instruction-memory request/response bus (rev 1.0)
// ------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_queue : 2-entry synchronous FIFO of {pc, instr} (rev 1.0)
// ------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t push_data,
  output fq_entry_t head,
  output logic [1:0] count
);

  // Single-bit pointers: the queue depth is fixed at two entries.
  fq_entry_t slots [DEPTH];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      full;
  logic      do_pop;
  logic      do_push;

  assign full    = (count == 2'(DEPTH));
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      assert (!(push && full && !do_pop));
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit : PC, in-order imem requests (<=2 in flight), IF/ID queue (rev 1.0)
// ------------------------------------------------------------------
module fetch_unit #(
  parameter logic [fetch_pkg::XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pc_stall,
  input  logic                      id_stall,
  input  logic                      redirect_valid,
  input  logic [fetch_pkg::XLEN-1:0] redirect_pc,
  fetch_unit_if.master              imem,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [fetch_pkg::XLEN-1:0] if_pc
);
  import fetch_pkg::*;

  logic [XLEN-1:0] pc;
  logic [1:0]      outstanding;
  logic [1:0]      discard;
  logic [XLEN-1:0] req_pc [2];
  logic [1:0]      q_count;
  fq_entry_t       q_head;
  fq_entry_t       q_push_data;
  logic            pop;
  logic            rsp;
  logic            take;
  logic            accept;
  logic [2:0]      credit;
  logic [1:0]      slot;
  logic            unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  assign rsp      = imem.imem_rvalid;
  assign take     = rsp && (discard == 2'd0);
  assign if_valid = (q_count != 2'd0);
  assign pop      = if_valid && !id_stall;

  // Queue slots + in-flight + to-be-dropped never exceed DEPTH, so this cannot underflow.
  assign credit = 3'(DEPTH) + 3'(pop) - 3'(q_count) - 3'(outstanding) - 3'(discard);

  assign imem.imem_req  = rst_n && !pc_stall && !redirect_valid && (credit != 3'd0);
  assign imem.imem_addr = pc;
  assign accept         = imem.imem_req && imem.imem_ready;

  assign q_push_data = '{pc: req_pc[0], instr: imem.imem_rdata};
  assign if_instr    = if_valid ? q_head.instr : NOP_INSTR;
  assign if_pc       = if_valid ? q_head.pc : '0;

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (take),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (q_push_data),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[XLEN-1:2], 2'b00};
      outstanding <= 2'd0;
      // Everything still in flight (old discards included) must be dropped on return.
      discard     <= discard + outstanding - 2'(rsp);
    end else begin
      if (accept) pc <= pc + XLEN'(4);
      outstanding <= outstanding + 2'(accept) - 2'(take);
      if (rsp && !take) discard <= discard - 2'd1;
    end
  end

  // Request-PC shadow, oldest at [0]; a new PC lands behind the survivors.
  assign slot = outstanding - 2'(take);

  always_ff @(posedge clk) begin
    if (take)   req_pc[0] <= req_pc[1];
    if (accept) req_pc[slot[0]] <= pc;
  end

endmodule
`default_nettype wire
